// File: rtl/eth_frame_rx_mf.sv
// Multi-address LRC-protected frame receiver: parses a gapped byte stream, filters the
// destination MAC, streams the payload and reports status. Optional counters: ETH_RX_STATUS_CNT_EN.
module eth_frame_rx_mf #(
  parameter int                      NUM_ADDR     = 2,
  parameter logic [NUM_ADDR*48-1:0]  ADDR_TABLE   = {48'h00_0a_95_9d_68_17, 48'h00_0a_95_9d_68_16},
  parameter bit                      BCAST_EN     = 1'b1,
  parameter int                      PREAMBLE_LEN = 7,
  parameter int                      MAX_PAYLOAD  = 1500,
  parameter int                      FCS_BYTES    = 4,
  parameter int                      CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  input  logic             start,
  output logic             rx_ready,
  output logic [7:0]       out_data,
  output logic             out_vld,
  output logic             out_sop,
  output logic             out_eop,
  output logic             done,
  output logic             done_ok,
  output logic [2:0]       done_code,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic [CNT_W-1:0] cnt_drop
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_MACDST, S_MACSRC, S_LEN, S_PAYLOAD, S_FCS, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_OK      = 3'd0,
    C_BAD_PRE = 3'd1,
    C_BAD_SFD = 3'd2,
    C_BAD_LEN = 3'd3,
    C_LRC     = 3'd4,
    C_ABORT   = 3'd5,
    C_DROP    = 3'd6
  } code_e;

  // The preamble start beat is consumed in IDLE, so PREAMBLE sees one byte fewer.
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 2);
  localparam logic [15:0] FCS_LAST = 16'(FCS_BYTES - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  state_e              state_q, state_d;
  code_e               code_q, code_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         len_q, len_d;
  logic [NUM_ADDR-1:0] match_q, match_d;
  logic                bcast_q, bcast_d;
  logic [7:0]          lrc_q, lrc_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_vld_q, out_vld_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;

  logic [NUM_ADDR-1:0] hit_vec;
  logic                bcast_hit;
  logic [7:0]          lrc_sum;
  logic [15:0]         len_full;

  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < NUM_ADDR; k++) begin
      hit_vec[k] = match_q[k] & (in_data == ADDR_TABLE[k*48 + 8*int'(cnt_q[2:0]) +: 8]);
    end
  end

  assign bcast_hit = BCAST_EN & bcast_q & (in_data == 8'hFF);
  assign lrc_sum   = lrc_q + in_data;
  assign len_full  = {in_data, len_q[7:0]};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    match_d    = match_q;
    bcast_d    = bcast_q;
    lrc_d      = lrc_q;
    out_data_d = out_data_q;
    out_vld_d  = 1'b0;
    out_sop_d  = 1'b0;
    out_eop_d  = 1'b0;

    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (in_vld) begin
      if (start && state_q != S_IDLE) begin
        state_d = S_DONE;
        code_d  = C_ABORT;
      end else begin
        cnt_d = cnt_q + 16'd1;
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (in_data == 8'hAA) begin
                state_d = (PREAMBLE_LEN == 1) ? S_SFD : S_PREAMBLE;
              end else begin
                state_d = S_DONE;
                code_d  = C_BAD_PRE;
              end
            end
          end
          S_PREAMBLE: begin
            if (in_data != 8'hAA) begin
              state_d = S_DONE;
              code_d  = C_BAD_PRE;
            end else if (cnt_q == PRE_LAST) begin
              state_d = S_SFD;
            end
          end
          S_SFD: begin
            if (in_data == 8'hAB) begin
              state_d = S_MACDST;
              match_d = '1;
              bcast_d = 1'b1;
              lrc_d   = 8'h00;
            end else begin
              state_d = S_DONE;
              code_d  = C_BAD_SFD;
            end
          end
          S_MACDST: begin
            lrc_d   = lrc_sum;
            match_d = hit_vec;
            bcast_d = bcast_hit;
            if (hit_vec == '0 && !bcast_hit) begin
              state_d = S_DONE;
              code_d  = C_DROP;
            end else if (cnt_q == 16'd5) begin
              state_d = S_MACSRC;
            end
          end
          S_MACSRC: begin
            lrc_d = lrc_sum;
            if (cnt_q == 16'd5) state_d = S_LEN;
          end
          S_LEN: begin
            lrc_d = lrc_sum;
            if (cnt_q == 16'd0) begin
              len_d = {8'h00, in_data};
            end else begin
              len_d = len_full;
              if (len_full == 16'd0 || len_full > MAX_LEN) begin
                state_d = S_DONE;
                code_d  = C_BAD_LEN;
              end else begin
                state_d = S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            lrc_d      = lrc_sum;
            out_vld_d  = 1'b1;
            out_data_d = in_data;
            out_sop_d  = (cnt_q == 16'd0);
            out_eop_d  = (cnt_q == len_q - 16'd1);
            if (out_eop_d) state_d = S_FCS;
          end
          S_FCS: begin
            lrc_d = lrc_sum;
            if (cnt_q == FCS_LAST) begin
              state_d = S_DONE;
              code_d  = (lrc_sum == 8'h00) ? C_OK : C_LRC;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      state_q    <= S_IDLE;
      code_q     <= C_OK;
      cnt_q      <= '0;
      len_q      <= '0;
      match_q    <= '0;
      bcast_q    <= 1'b0;
      lrc_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      match_q    <= match_d;
      bcast_q    <= bcast_d;
      lrc_q      <= lrc_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
    end
  end

  assign rx_ready  = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign done_ok   = done && (code_q == C_OK);
  assign done_code = done ? code_q : 3'd0;
  assign out_data  = out_data_q;
  assign out_vld   = out_vld_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;

`ifdef ETH_RX_STATUS_CNT_EN
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

  // Saturating counters, bumped once per DONE cycle.
  always_comb begin
    cnt_ok_d   = cnt_ok_q;
    cnt_err_d  = cnt_err_q;
    cnt_drop_d = cnt_drop_q;
    if (done) begin
      case (code_q)
        C_OK:    if (cnt_ok_q != '1)   cnt_ok_d   = cnt_ok_q + CNT_W'(1);
        C_DROP:  if (cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + CNT_W'(1);
        default: if (cnt_err_q != '1)  cnt_err_d  = cnt_err_q + CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok_q   <= '0;
      cnt_err_q  <= '0;
      cnt_drop_q <= '0;
    end else begin
      cnt_ok_q   <= cnt_ok_d;
      cnt_err_q  <= cnt_err_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign cnt_ok   = cnt_ok_q;
  assign cnt_err  = cnt_err_q;
  assign cnt_drop = cnt_drop_q;
`else
  assign cnt_ok   = '0;
  assign cnt_err  = '0;
  assign cnt_drop = '0;
`endif

endmodule

// File: tb/tb_eth_frame_rx_mf.sv
// Self-checking bench for eth_frame_rx_mf: frame-level vector table plus hand-written
// abort and mid-frame reset sequences; payload stream checked every cycle by a monitor.
module tb_eth_frame_rx_mf;

  localparam int          PAY_BASE = 22;
  localparam logic [47:0] E0 = 48'h00_0a_95_9d_68_16;
  localparam logic [47:0] E1 = 48'h00_0a_95_9d_68_17;
  localparam logic [47:0] BC = 48'hFF_FF_FF_FF_FF_FF;
`ifdef ETH_RX_STATUS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        start;
  logic        rx_ready;
  logic [7:0]  out_data;
  logic        out_vld, out_sop, out_eop;
  logic        done, done_ok;
  logic [2:0]  done_code;
  logic [15:0] cnt_ok, cnt_err, cnt_drop;

  eth_frame_rx_mf dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .start(start),
    .rx_ready(rx_ready), .out_data(out_data), .out_vld(out_vld), .out_sop(out_sop),
    .out_eop(out_eop), .done(done), .done_ok(done_ok), .done_code(done_code),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [47:0] dst;
    logic [15:0] len;
    int          bad_idx;
    logic [7:0]  bad_val;
    logic [7:0]  lrc_off;
    bit          gaps;
    logic [2:0]  exp_code;
    int          exp_beats;
    int          done_at;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected payload stream, delayed one cycle from the driven beat.
  logic       tag_vld = 1'b0, tag_sop = 1'b0, tag_eop = 1'b0;
  logic [7:0] tag_data = 8'h00;
  logic       tag_vld_q = 1'b0, tag_sop_q = 1'b0, tag_eop_q = 1'b0;
  logic [7:0] tag_data_q = 8'h00;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    tag_vld_q  <= tag_vld;
    tag_sop_q  <= tag_sop;
    tag_eop_q  <= tag_eop;
    tag_data_q <= tag_data;
  end

  int         done_total = 0;
  int         beat_total = 0;
  int         done_cyc_s = 0;
  logic [2:0] done_code_s = 3'd0;
  logic       done_ok_s = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld || tag_vld_q) begin
        check("out_vld", 32'(out_vld), 32'(tag_vld_q));
        if (tag_vld_q) begin
          check("out_data", 32'(out_data), 32'(tag_data_q));
          check("out_sop", 32'(out_sop), 32'(tag_sop_q));
          check("out_eop", 32'(out_eop), 32'(tag_eop_q));
        end
      end
      if (out_vld) beat_total++;
      if (done) begin
        done_total++;
        done_code_s = done_code;
        done_ok_s   = done_ok;
        done_cyc_s  = cyc;
        check("done_with_eop", 32'(out_eop), 32'd0);
      end
    end
  end

  logic [7:0] fr[$];
  int         bcyc[2048];
  int         exp_ok = 0, exp_err = 0, exp_drop = 0;

  task automatic build(input logic [47:0] dst, input logic [15:0] len, input int npay,
                       input logic [7:0] off, input int bad_idx, input logic [7:0] bad_val);
    logic [7:0] sum;
    sum = 8'h00;
    fr.delete();
    repeat (7) fr.push_back(8'hAA);
    fr.push_back(8'hAB);
    for (int i = 0; i < 6; i++) fr.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'(i + 1));
    fr.push_back(len[7:0]);
    fr.push_back(len[15:8]);
    for (int i = 0; i < npay; i++) fr.push_back(8'(i + 1));
    for (int i = 8; i < fr.size(); i++) sum = sum + fr[i];
    fr.push_back(8'h5A);
    fr.push_back(8'h00);
    fr.push_back(8'h00);
    fr.push_back(8'h00 - sum - 8'h5A + off);
    if (bad_idx >= 0) fr[bad_idx] = bad_val;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_vld  = 1'b0;
      start   = 1'b0;
      in_data = 8'($urandom);
      tag_vld = 1'b0;
      tag_sop = 1'b0;
      tag_eop = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send(input int first, input int last, input bit gaps, input bit streams,
                      input int len);
    for (int i = first; i <= last; i++) begin
      if (gaps) idle($urandom_range(0, 1));
      in_data  = fr[i];
      in_vld   = 1'b1;
      start    = (i == 0);
      tag_vld  = streams && i >= PAY_BASE && i < PAY_BASE + len;
      tag_data = fr[i];
      tag_sop  = tag_vld && i == PAY_BASE;
      tag_eop  = tag_vld && i == PAY_BASE + len - 1;
      bcyc[i]  = cyc + 1;
      @(negedge clk);
    end
  endtask

  task automatic check_cnts(input string name);
    check({name, "_cnt_ok"},   32'(cnt_ok),   CNT_EN ? 32'(exp_ok)   : 32'd0);
    check({name, "_cnt_err"},  32'(cnt_err),  CNT_EN ? 32'(exp_err)  : 32'd0);
    check({name, "_cnt_drop"}, 32'(cnt_drop), CNT_EN ? 32'(exp_drop) : 32'd0);
  endtask

  task automatic account(input logic [2:0] code);
    if (code == 3'd0)      exp_ok++;
    else if (code == 3'd6) exp_drop++;
    else                   exp_err++;
  endtask

  initial begin
    vec_t v;
    int   d0, b0, npay, didx, ab_cyc;

    rst = 1'b1; in_vld = 1'b0; start = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_code", 32'(done_code), 32'd0);
    check_cnts("rst");

    vecs[0] = '{"ok_e0",         E0,              16'd4,    -1, 8'h00, 8'h00, 1'b0, 3'd0, 4,    -1};
    vecs[1] = '{"ok_e1_gaps",    E1,              16'd4,    -1, 8'h00, 8'h00, 1'b1, 3'd0, 4,    -1};
    vecs[2] = '{"drop",          48'h112233445566, 16'd4,   -1, 8'h00, 8'h00, 1'b0, 3'd6, 0,    8};
    vecs[3] = '{"ok_len1",       E0,              16'd1,    -1, 8'h00, 8'h00, 1'b0, 3'd0, 1,    -1};
    vecs[4] = '{"bcast_bad_lrc", BC,              16'd4,    -1, 8'h00, 8'h01, 1'b0, 3'd4, 4,    -1};
    vecs[5] = '{"len_1501",      E0,              16'd1501, -1, 8'h00, 8'h00, 1'b0, 3'd3, 0,    21};
    vecs[6] = '{"len_0",         E0,              16'd0,    -1, 8'h00, 8'h00, 1'b0, 3'd3, 0,    21};
    vecs[7] = '{"bad_pre3",      E0,              16'd4,    3,  8'hAB, 8'h00, 1'b0, 3'd1, 0,    3};
    vecs[8] = '{"bad_sfd",       E0,              16'd4,    7,  8'hAA, 8'h00, 1'b0, 3'd2, 0,    7};
    vecs[9] = '{"max_len_gaps",  E1,              16'd1500, -1, 8'h00, 8'h00, 1'b1, 3'd0, 1500, -1};

    for (int n = 0; n < 10; n++) begin
      v    = vecs[n];
      npay = (v.exp_code == 3'd3) ? 2 : int'(v.len);
      build(v.dst, v.len, npay, v.lrc_off, v.bad_idx, v.bad_val);
      d0 = done_total;
      b0 = beat_total;
      send(0, fr.size() - 1, v.gaps, v.exp_code == 3'd0 || v.exp_code == 3'd4, int'(v.len));
      idle(4);
      didx = (v.done_at >= 0) ? v.done_at : fr.size() - 1;
      check({v.name, "_done_cnt"}, 32'(done_total - d0), 32'd1);
      check({v.name, "_code"}, 32'(done_code_s), 32'(v.exp_code));
      check({v.name, "_ok"}, 32'(done_ok_s), 32'(v.exp_code == 3'd0));
      check({v.name, "_beats"}, 32'(beat_total - b0), 32'(v.exp_beats));
      check({v.name, "_done_cyc"}, 32'(done_cyc_s), 32'(bcyc[didx]));
      check({v.name, "_rx_ready"}, 32'(rx_ready), 32'd1);
      account(v.exp_code);
      check_cnts(v.name);
    end

    // start during payload byte 2 aborts; that beat and the following plain beats are dropped
    build(E0, 16'd4, 4, 8'h00, -1, 8'h00);
    d0 = done_total;
    b0 = beat_total;
    send(0, PAY_BASE + 1, 1'b0, 1'b1, 4);
    in_data = fr[PAY_BASE + 2]; in_vld = 1'b1; start = 1'b1;
    tag_vld = 1'b0; tag_sop = 1'b0; tag_eop = 1'b0;
    ab_cyc = cyc + 1;
    @(negedge clk);
    repeat (3) begin
      in_data = 8'hAA; in_vld = 1'b1; start = 1'b0;
      @(negedge clk);
    end
    idle(4);
    check("abort_done_cnt", 32'(done_total - d0), 32'd1);
    check("abort_code", 32'(done_code_s), 32'd5);
    check("abort_ok", 32'(done_ok_s), 32'd0);
    check("abort_beats", 32'(beat_total - b0), 32'd2);
    check("abort_done_cyc", 32'(done_cyc_s), 32'(ab_cyc));
    account(3'd5);
    check_cnts("abort");

    // reset in the middle of MACSRC
    build(E1, 16'd4, 4, 8'h00, -1, 8'h00);
    d0 = done_total;
    send(0, 16, 1'b0, 1'b1, 4);
    rst = 1'b1; in_vld = 1'b0; start = 1'b0;
    @(negedge clk);
    check("mrst_rx_ready", 32'(rx_ready), 32'd1);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_out_vld", 32'(out_vld), 32'd0);
    exp_ok = 0; exp_err = 0; exp_drop = 0;
    check_cnts("mrst");
    rst = 1'b0;
    idle(4);
    check("mrst_no_done", 32'(done_total - d0), 32'd0);

    build(E0, 16'd4, 4, 8'h00, -1, 8'h00);
    d0 = done_total;
    send(0, fr.size() - 1, 1'b0, 1'b1, 4);
    idle(4);
    check("recover_done_cnt", 32'(done_total - d0), 32'd1);
    check("recover_code", 32'(done_code_s), 32'd0);
    account(3'd0);
    check_cnts("recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_rx_mf.md
Name: eth_frame_rx_mf

Overview:
- Parametrised successor to the single-address byte receiver.
- Parses an LRC-protected frame from a gapped byte stream: preamble, SFD, dst MAC, src MAC, length, payload, FCS.
- Filters the destination against a table of up to NUM_ADDR MACs plus optional broadcast, and streams the payload out with sop/eop.
- Reports a per-frame completion status to the link controller.

Parameters:
- NUM_ADDR, 2, number of accepted destination MAC entries (1..8).
- ADDR_TABLE, {48'h00_0a_95_9d_68_17, 48'h00_0a_95_9d_68_16}, packed NUM_ADDR*48 bits; entry k = ADDR_TABLE[k*48+:48].
- BCAST_EN, 1, when 1 also accept 48'hFFFF_FFFF_FFFF.
- PREAMBLE_LEN, 7, number of 8'hAA bytes before the SFD (1..15).
- MAX_PAYLOAD, 1500, maximum legal payload length in bytes.
- FCS_BYTES, 4, FCS field length (1..4).
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  received byte
- in_vld  in  1  in_data valid this cycle (a beat); gaps are allowed anywhere
- start  in  1  marks the first preamble beat
- rx_ready  out  1  high in IDLE
- out_data  out  8  payload byte
- out_vld  out  1  out_data valid
- out_sop  out  1  first payload byte
- out_eop  out  1  last payload byte
- done  out  1  one-cycle frame-complete pulse
- done_ok  out  1  with done: frame accepted
- done_code  out  3  with done: 0 ok, 1 bad preamble, 2 bad SFD, 3 bad length, 4 LRC fail, 5 abort, 6 addr drop
- cnt_ok, cnt_err, cnt_drop  out  CNT_W each  status counters

Behaviour:
- Reset values: all outputs 0 except rx_ready=1. The FSM returns to IDLE from any state; counters clear.
- All parsing advances only on beats (in_vld=1). Non-beat cycles hold all state.
- States: IDLE, PREAMBLE, SFD, MACDST, MACSRC, LEN, PAYLOAD, FCS, DONE.
- Per-state byte counter: 16 bits, cleared on every state change.
- IDLE: a beat with start=1 is preamble byte 0. A beat without start is ignored.
- PREAMBLE: every byte must be 8'hAA, else DONE with code 1. After PREAMBLE_LEN good bytes, go to SFD.
- SFD: one byte, must be 8'hAB, else code 2.
- MACDST: 6 bytes, LSB first; byte i compares with entry[i*8+:8].
  - Per-entry match vector is initialised all-ones at SFD and ANDed on each byte; broadcast is tracked the same way.
  - Vector all zero at any byte → DONE with code 6 immediately; remaining bytes are ignored until the next start.
- MACSRC: 6 bytes, no check.
- LEN: 2 bytes, little-endian, into payload_len.
  - payload_len==0 or >MAX_PAYLOAD → DONE with code 3 on the second LEN byte.
- PAYLOAD: exactly payload_len bytes.
- FCS: FCS_BYTES bytes.
- LRC: 8-bit modulo-256 sum, cleared at SFD, summed over all bytes from MACDST through FCS inclusive.
  - After the last FCS byte, lrc==8'h00 → code 0, else code 4.
- DONE: one cycle. done=1; done_ok=(code==0); done_code valid. Then IDLE.
- start on a beat in any state other than IDLE/DONE → DONE with code 5. That start beat is not reused.
- Payload output: each payload beat appears on out_data with out_vld=1 exactly one cycle later (registered).
  - out_sop on the first payload byte; out_eop on byte payload_len-1.
  - No backpressure. Downstream discards the frame if done_ok=0.
- done fires at least one cycle after out_eop. Never simultaneous.
- Counters: each saturates at all-ones.
  - cnt_ok += code 0.
  - cnt_drop += code 6.
  - cnt_err += codes 1–5.
- Reset mid-frame: no done pulse; counters clear.

Optional Feature:
- Macro: ETH_RX_STATUS_CNT_EN.
- Defined: cnt_ok, cnt_err and cnt_drop are implemented as above.
- Undefined: no counter registers; the three ports are tied to 0. All other behaviour is identical.

Test Plan:
- Good frame to entry 0, defaults, no gaps, payload_len=4 (payload 01 02 03 04), FCS 4 bytes with LRC total 0 → out_vld 4 beats 01..04, sop on 01, eop on 04, then done=1, done_code=0, cnt_ok=1.
- Same frame to entry 1 with random in_vld gaps (≈50% duty) → identical output data/sop/eop and done_code=0. Each out_vld is exactly 1 cycle after its payload beat.
- dst 11_22_33_44_55_66 → done_code=6 on the first dst byte (8'h66), no out_vld, cnt_drop=1. Next good frame is still accepted.
- Broadcast dst, BCAST_EN=1, bad FCS (LRC total 8'h01) → 4 payload beats streamed, then done_code=4, done_ok=0, cnt_err=1.
- LEN bytes DD 05 (1501) → done_code=3 after the second LEN byte, no out_vld. Separately, preamble byte 3 = 8'hAB → code 1.
- start pulsed during PAYLOAD byte 2 → done_code=5. Separately, rst during MACSRC → rx_ready=1 next cycle, no done, counters 0.
